// File: rtl/vecn_alu_seq.sv
// Multi-cycle N-lane signed fixed-point vector ALU: ADD, SUB, SCALE, DOT, NORMALIZE.
// One shared multiplier feeds a wide accumulator; NORMALIZE then runs a bit-serial
// square root and a restoring divider so every opcode has a fixed, data-independent latency.
module vecn_alu_seq #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 16,
  parameter int unsigned N    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  input  logic [W-1:0]   s,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] r,
  output logic           err
);

  localparam int unsigned RW  = W + FRAC;   // radicand / dividend width
  localparam int unsigned HW  = RW / 2;     // square-root result width
  localparam int unsigned SR  = HW + 2;     // square-root partial remainder width
  localparam int unsigned AW  = 2 * W + 2;  // dot-product accumulator width
  localparam int unsigned CW  = $clog2(RW);
  localparam int unsigned LW  = $clog2(N);

  localparam logic [2:0] OpAdd   = 3'd0;
  localparam logic [2:0] OpSub   = 3'd1;
  localparam logic [2:0] OpScale = 3'd2;
  localparam logic [2:0] OpDot   = 3'd3;
  localparam logic [2:0] OpNorm  = 3'd4;

  typedef enum logic [2:0] {StIdle, StMac, StSqrt, StDiv, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [N*W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]     s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    rad_q, rad_d;
  logic [SR-1:0]    sq_rem_q, sq_rem_d;
  logic [HW-1:0]    root_q, root_d;
  logic [RW-1:0]    dvd_q, dvd_d;
  logic [HW-1:0]    drem_q, drem_d;
  logic [W-2:0]     quo_q, quo_d;
  logic             bad_q, bad_d;
  logic [N*W-1:0]   r_q, r_d;
  logic             err_q, err_d;

  logic             accept;
  logic [LW-1:0]    mac_lane;
  logic signed [W-1:0]   mul_x, mul_y;
  logic signed [2*W-1:0] prod;
  logic [W-1:0]     dot_val;
  logic             mag_bad;
  logic [SR+1:0]    sq_t, sq_trial;
  logic             sq_ge;
  logic [W-1:0]     div_x, div_abs, div_res;
  logic             div_neg, div_first, div_ge;
  logic [RW-1:0]    dvd_cur;
  logic [HW-1:0]    drem_cur;
  logic [W-2:0]     quo_cur;
  logic [HW:0]      div_t, divisor;
  logic [W-1:0]     quo_full;

  function automatic logic [W-1:0] get_lane(input logic [N*W-1:0] v, input logic [LW-1:0] idx);
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == LW'(i)) res = v[i*W +: W];
    end
    return res;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state sequencing; every path has a fixed cycle count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (op == OpScale || op == OpDot || op == OpNorm) state_d = StMac;
          else                                              state_d = StDone;
        end
      end
      StMac: begin
        if (op_q == OpScale) begin
          if (cnt_q == CW'(N - 1)) state_d = StDone;
        end else if (cnt_q == CW'(N)) begin
          state_d = (op_q == OpNorm) ? StSqrt : StDone;
        end
      end
      StSqrt:  if (cnt_q == CW'(HW - 1)) state_d = StDiv;
      StDiv:   if (cnt_q == CW'(RW - 1) && lane_q == LW'(N - 1)) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and result outputs.
  always_comb begin
    in_ready  = (state_q == StIdle) & rst_n;
    out_valid = (state_q == StDone);
    r         = r_q;
    err       = err_q;
  end

  // Shared multiplier, square-root step and divider step.
  always_comb begin
    accept   = in_valid & in_ready;
    mac_lane = cnt_q[LW-1:0];
    mul_x    = $signed(get_lane(a_q, mac_lane));
    if (op_q == OpScale)    mul_y = $signed(s_q);
    else if (op_q == OpDot) mul_y = $signed(get_lane(b_q, mac_lane));
    else                    mul_y = mul_x;
    prod     = mul_x * mul_y;
    dot_val  = acc_q[FRAC +: W];
    mag_bad  = dot_val[W-1] | (dot_val == '0);

    sq_t     = {sq_rem_q, rad_q[RW-1 -: 2]};
    sq_trial = (SR + 2)'({root_q, 2'b01});
    sq_ge    = (sq_t >= sq_trial);

    div_x     = get_lane(a_q, lane_q);
    div_neg   = div_x[W-1];
    div_abs   = div_neg ? (~div_x + 1'b1) : div_x;
    div_first = (cnt_q == '0);
    dvd_cur   = div_first ? {div_abs, {FRAC{1'b0}}} : dvd_q;
    drem_cur  = div_first ? '0 : drem_q;
    quo_cur   = div_first ? '0 : quo_q;
    div_t     = {drem_cur, dvd_cur[RW-1]};
    divisor   = (HW + 1)'(root_q);
    div_ge    = (div_t >= divisor);
    quo_full  = {quo_cur, div_ge};
    if (bad_q)        div_res = '0;
    else if (div_neg) div_res = ~quo_full + 1'b1;
    else              div_res = quo_full;
  end

  // Datapath next-state: capture on accept, then step per sequencer state.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    acc_d    = acc_q;
    rad_d    = rad_q;
    sq_rem_d = sq_rem_q;
    root_d   = root_q;
    dvd_d    = dvd_q;
    drem_d   = drem_q;
    quo_d    = quo_q;
    bad_d    = bad_q;
    r_d      = r_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = op;
          a_d    = a;
          b_d    = b;
          s_d    = s;
          cnt_d  = '0;
          lane_d = '0;
          acc_d  = '0;
          bad_d  = 1'b0;
          r_d    = '0;
          err_d  = 1'b0;
          case (op)
            OpAdd: begin
              for (int i = 0; i < N; i++) r_d[i*W +: W] = a[i*W +: W] + b[i*W +: W];
            end
            OpSub: begin
              for (int i = 0; i < N; i++) r_d[i*W +: W] = a[i*W +: W] - b[i*W +: W];
            end
            OpScale, OpDot, OpNorm: begin
              err_d = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StMac: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q < CW'(N)) begin
          acc_d = acc_q + {{(AW - 2 * W){prod[2*W-1]}}, prod};
          if (op_q == OpScale) begin
            for (int i = 0; i < N; i++) begin
              if (mac_lane == LW'(i)) r_d[i*W +: W] = prod[FRAC +: W];
            end
          end
        end else begin
          // Finalize: the shifted accumulator is either the DOT result or mag2.
          cnt_d = '0;
          if (op_q == OpDot) begin
            r_d[W-1:0] = dot_val;
          end else begin
            rad_d    = {dot_val, {FRAC{1'b0}}};
            sq_rem_d = '0;
            root_d   = '0;
            bad_d    = mag_bad;
            err_d    = mag_bad;
          end
        end
      end
      StSqrt: begin
        rad_d    = {rad_q[RW-3:0], 2'b00};
        sq_rem_d = SR'(sq_ge ? (sq_t - sq_trial) : sq_t);
        root_d   = {root_q[HW-2:0], sq_ge};
        cnt_d    = (cnt_q == CW'(HW - 1)) ? '0 : cnt_q + 1'b1;
        lane_d   = '0;
      end
      StDiv: begin
        dvd_d  = {dvd_cur[RW-2:0], 1'b0};
        drem_d = HW'(div_ge ? (div_t - divisor) : div_t);
        quo_d  = quo_full[W-2:0];
        if (cnt_q == CW'(RW - 1)) begin
          for (int i = 0; i < N; i++) begin
            if (lane_q == LW'(i)) r_d[i*W +: W] = div_res;
          end
          cnt_d  = '0;
          lane_d = lane_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers; reset clears everything, discarding any partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      lane_q   <= '0;
      acc_q    <= '0;
      rad_q    <= '0;
      sq_rem_q <= '0;
      root_q   <= '0;
      dvd_q    <= '0;
      drem_q   <= '0;
      quo_q    <= '0;
      bad_q    <= 1'b0;
      r_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      rad_q    <= rad_d;
      sq_rem_q <= sq_rem_d;
      root_q   <= root_d;
      dvd_q    <= dvd_d;
      drem_q   <= drem_d;
      quo_q    <= quo_d;
      bad_q    <= bad_d;
      r_q      <= r_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/vecn_alu_seq.md
Name: vecn_alu_seq

Overview:
- Parametrised, multi-cycle successor to the combinational 3-vector fixed-point ops.
- One shared multiplier, a bit-serial square root and a restoring divider execute ADD, SUB, SCALE, DOT and NORMALIZE on N-lane signed fixed-point vectors.
- Valid/ready handshake on both sides; sits between the ray-setup logic and the shading pipeline.
- Trades area for latency so NORMALIZE fits the tile budget.

Parameters:
- W, 32, total lane width in bits (signed two's complement).
- FRAC, 16, fractional bits; (W+FRAC) must be even.
- N, 3, lane count, legal range 2..4.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block accepts; transfer when in_valid & in_ready.
- op  in  3  0 ADD, 1 SUB, 2 SCALE, 3 DOT, 4 NORMALIZE, 5-7 illegal.
- a  in  N*W  vector A, lane i at [i*W +: W].
- b  in  N*W  vector B (ADD/SUB/DOT); ignored otherwise.
- s  in  W  scalar for SCALE; ignored otherwise.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- r  out  N*W  result vector; DOT result in lane 0, other lanes 0.
- err  out  1  qualified by out_valid: illegal op, or NORMALIZE with squared magnitude <= 0.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE, out_valid=0, r=0, err=0, all internal registers 0. This applies from any state, including mid-operation; the partial result is discarded. in_ready=0 while rst_n is low.
- States: IDLE, MAC, SQRT, DIV, DONE. in_ready = (state==IDLE) & rst_n. op/a/b/s are captured on accept; input changes afterwards have no effect.
- ADD/SUB/illegal: IDLE->DONE. out_valid rises 1 cycle after the accept edge. Lane-wise wrap-around add/sub. Illegal op: r=0, err=1.
- SCALE: MAC for N cycles, one lane per cycle, lane 0 first. r[i] = (a[i]*s) >>> FRAC.
  - Product is full 2W; the arithmetic shift floors; the low W bits are kept (wrap). Latency N+1.
- DOT: MAC for N cycles into a (2W+2)-bit signed accumulator of full products, then one cycle finalize: r[0] = low W bits of (acc >>> FRAC). Latency N+2.
- NORMALIZE:
  - mag2 = DOT(a,a), computed in MAC as above (N+1 cycles, including finalize).
  - SQRT: (W+FRAC)/2 cycles, bit-serial. mag = floor(sqrt(mag2 << FRAC)), with the radicand treated as unsigned W+FRAC bits.
  - DIV: N lanes, W+FRAC cycles each, restoring division on magnitudes. r[i] = (a[i] << FRAC) / mag, truncated toward zero, sign = sign of a[i]; low W bits kept.
  - Then DONE.
  - Total latency fixed at (N+1) + (W+FRAC)/2 + N*(W+FRAC) + 1, which is 173 at defaults, independent of data.
  - If mag2 <= 0: the sequencer still runs the full latency, all lanes = 0, err=1.
- DONE: out_valid=1, r/err held stable until out_ready; the handshake returns to IDLE next cycle. in_ready is low throughout DONE, and in_valid is ignored there.
- Minimum issue interval: latency + 1 cycle with out_ready held high.
- Latency is counted from the accept edge to the first edge on which out_valid=1.

Test Plan (Q16.16, N=3 defaults):
- ADD a=(0x00010000,0x00020000,0xFFFD0000), b=(0x00008000,0x00008000,0x00008000) -> r=(0x00018000,0x00028000,0xFFFD8000), err=0, out_valid at +1.
- SCALE a=(0x00018000,0xFFFE0000,0x00004000), s=0x00020000 -> r=(0x00030000,0xFFFC0000,0x00008000) at +4.
- DOT a=(1.0,2.0,3.0), b=(4.0,5.0,6.0) -> r[0]=0x00200000, r[1]=r[2]=0, at +5.
- NORMALIZE a=(3.0,4.0,0) -> r=(0x00009999,0x0000CCCC,0), err=0, out_valid exactly at +173. Same for a=(-3.0,0,4.0) -> r=(0xFFFF6667,0,0x0000CCCC).
- NORMALIZE a=(0,0,0) -> r=0, err=1 at +173; op=6 -> r=0, err=1 at +1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid; r stable, in_ready=0, pulsed in_valid not accepted. Separately, drop rst_n for one edge 50 cycles into NORMALIZE -> out_valid=0, r=0, in_ready=1 the cycle after rst_n returns high, and no stale result appears.
